approx_prod_acc: RTL
====================

// Module: approx_prod_acc
// PURPOSE
//  Downstream consumer of the 8x8 approximate multiplier output (16-bit product R).
//  Accumulates a stream of products into one sum (dot-product / MAC tail) using a
//  valid/ready handshake, then presents the sum, beat count and status flags.
//  Sits between the combinational multiplier and the result sink / error-metric logger.
// PARAMETERS
//  PROD_W   16  width of incoming product (multiplier R)
//  ACC_W    20  accumulator / result width, ACC_W >= PROD_W
//  MAX_LEN  32  maximum beats per accumulation; count width CW = $clog2(MAX_LEN+1)
//  SATURATE 1   1: clamp sum at 2^ACC_W-1 on overflow; 0: wrap modulo 2^ACC_W
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous active-high reset
//  prod_valid in   1      product beat present
//  prod_ready out  1      block accepts beat this cycle
//  prod       in   PROD_W unsigned product from multiplier
//  prod_last  in   1      beat is final term of current sum
//  acc_valid  out  1      result held
//  acc_ready  in   1      sink takes result
//  acc_data   out  ACC_W  accumulated sum
//  acc_len    out  CW     number of beats summed
//  acc_ovf    out  1      sticky: at least one add overflowed ACC_W
//  acc_trunc  out  1      sum force-closed at MAX_LEN without prod_last
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; acc_data=0, acc_len=0, acc_ovf=0,
//   acc_trunc=0, acc_valid=0. Any partial sum is discarded on reset mid-stream.
//  Beat accepted when prod_valid & prod_ready at rising clk. prod_ready is combinational
//   from state only: 1 in IDLE and ACCUM, 0 in HOLD (no input-to-output path).
//  States:
//   IDLE : accept -> acc<=zext(prod), len<=1, ovf<=0, trunc<=0;
//          -> HOLD if prod_last (or MAX_LEN==1), else ACCUM.
//   ACCUM: accept -> acc<=acc+zext(prod) (ACC_W+1-bit add), len<=len+1;
//          carry out -> ovf<=1 and acc<=all-ones (SATURATE=1) or low ACC_W bits (0);
//          once saturated, acc stays all-ones for the rest of the sum.
//          -> HOLD if prod_last, or if new len==MAX_LEN (set trunc<=1 when !prod_last).
//          no beat -> hold everything (gaps in prod_valid allowed).
//   HOLD : acc_valid=1; acc_data/len/ovf/trunc stable while acc_ready=0.
//          acc_ready -> IDLE, acc_valid=0 next cycle; data regs retain value until
//          next first beat overwrites them.
//  Latency: acc_valid rises the cycle after the last beat is accepted. Minimum
//   throughput: one beat/cycle inside a sum; one bubble cycle per sum (HOLD->IDLE),
//   i.e. a prod_valid asserted during HOLD waits, even if acc_ready=1 that cycle.
//  prod_last on first beat gives a 1-term sum (len=1). prod_last during HOLD ignored
//   (not accepted). prod and prod_last are sampled only on accepted beats.
//  acc_valid/acc_data obey AXI-style stability: once valid, no change until taken.
//  All arithmetic unsigned; prod zero-extended to ACC_W.
// TESTING
//  T1 reset mid-sum: 3 beats of 100, assert rst -> all outputs 0, state IDLE; next
//     single beat 7 w/ last -> acc_data=7, acc_len=1.
//  T2 4 beats {65025,1,0,300}, last on 4th, acc_ready=1 -> acc_data=65326, len=4,
//     ovf=0, trunc=0, acc_valid one cycle after 4th accept.
//  T3 17 beats of 65025, last on 17th, SATURATE=1 -> acc_data=1048575, ovf=1, len=17;
//     SATURATE=0 -> acc_data=1105425 mod 2^20 = 56849, ovf=1.
//  T4 32 beats of 1, no prod_last -> closes at beat 32: acc_data=32, len=32, trunc=1;
//     33rd beat stalls (prod_ready=0) until result taken.
//  T5 backpressure: result held with acc_ready=0 for 5 cycles while prod_valid=1 ->
//     outputs stable, prod_ready=0; acc_ready=1 -> one bubble, next sum starts fresh.
//  T6 random valid/ready gaps, 1000 sums vs. reference model -> zero mismatches.

Source files
------------

// File: rtl/approx_prod_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// approx_prod_acc : valid/ready accumulator of approximate-multiplier products
// Rev 1.0
// ---------------------------------------------------------------------------
module approx_prod_acc #(
  parameter int PROD_W   = 16,
  parameter int ACC_W    = 20,
  parameter int MAX_LEN  = 32,
  parameter int SATURATE = 1,
  localparam int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_last,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CW-1:0]     acc_len,
  output logic              acc_ovf,
  output logic              acc_trunc
);

  localparam logic [CW-1:0] c_max_len = CW'(MAX_LEN);
  localparam logic          c_single  = (MAX_LEN == 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [ACC_W-1:0]   r_acc;
  logic [CW-1:0]      r_len;
  logic               r_ovf;
  logic               r_trunc;
  logic               w_accept;
  logic [ACC_W:0]     w_sum;
  logic [CW-1:0]      w_len_inc;
  logic               w_at_max;

  // Handshake outputs depend on state only, so there is no input-to-output path.
  assign prod_ready = (r_state != S_HOLD);
  assign acc_valid  = (r_state == S_HOLD);
  assign acc_data   = r_acc;
  assign acc_len    = r_len;
  assign acc_ovf    = r_ovf;
  assign acc_trunc  = r_trunc;

  always_comb begin
    w_state_nx = r_state;
    w_accept   = prod_valid & prod_ready;
    w_sum      = {1'b0, r_acc} + (ACC_W+1)'(prod);
    w_len_inc  = r_len + CW'(1);
    w_at_max   = (w_len_inc == c_max_len);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nx = (prod_last || c_single) ? S_HOLD : S_ACCUM;
      end
      S_ACCUM: begin
        if (w_accept && (prod_last || w_at_max)) w_state_nx = S_HOLD;
      end
      S_HOLD: begin
        if (acc_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Result registers keep their value after hand-off until the next first beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
      r_trunc <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc   <= ACC_W'(prod);
        r_len   <= CW'(1);
        r_ovf   <= 1'b0;
        r_trunc <= c_single & ~prod_last;
      end else begin
        r_len   <= w_len_inc;
        r_trunc <= w_at_max & ~prod_last;
        if (w_sum[ACC_W]) begin
          r_ovf <= 1'b1;
          r_acc <= (SATURATE != 0) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
        end else begin
          r_acc <= w_sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire
